// File: rtl/contador_sweep_ctrl.sv
// rtl/contador_sweep_ctrl.sv - triangular sweep sequencer for the contador up/down counter
//
// Drives an external up/down counter through clear -> ramp up to lim_hi ->
// dwell -> ramp down to lim_lo -> dwell, repeated reps times, watching the
// counter's cuenta value to decide each turn.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   start        one-cycle request, sampled only in IDLE
//   abort        return to IDLE from any non-IDLE state
//   lim_hi       upper turn value
//   lim_lo       lower turn value
//   dwell        hold cycles at each turn (0 behaves as 1)
//   reps         number of up/down periods (0 behaves as 1)
//   cuenta       current counter value
//   cnt_en       counter step enable (combinational)
//   cnt_up_down  1 = count up, 0 = count down
//   cnt_clr      counter clear request
//   busy         high in every state except IDLE
//   done         one-cycle pulse on normal completion
//   err          one-cycle pulse on bad configuration or stalled counter
//   cycle_cnt    completed periods

module contador_sweep_ctrl #(
    parameter int WIDTH = 8,
    parameter int REP_W = 4,
    parameter int WDOG  = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] lim_hi,
    input  logic [WIDTH-1:0] lim_lo,
    input  logic [REP_W-1:0] dwell,
    input  logic [REP_W-1:0] reps,
    input  logic [WIDTH-1:0] cuenta,
    output logic             cnt_en,
    output logic             cnt_up_down,
    output logic             cnt_clr,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [REP_W-1:0] cycle_cnt
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CLEAR    = 3'd1;
    localparam logic [2:0] S_RAMP_UP  = 3'd2;
    localparam logic [2:0] S_DWELL_HI = 3'd3;
    localparam logic [2:0] S_RAMP_DN  = 3'd4;
    localparam logic [2:0] S_DWELL_LO = 3'd5;
    localparam logic [2:0] S_FINISH   = 3'd6;

    // Watchdog counter holds 0..WDOG-1; reaching the last value without a
    // turn means the counter has stalled.
    localparam int              WD_W    = (WDOG > 1) ? $clog2(WDOG) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG - 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;

    // Configuration captured at start so the sweep ignores input changes.
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [REP_W-1:0] dw_q;
    logic [REP_W-1:0] rp_q;

    logic [REP_W-1:0] dw_cnt;
    logic [WD_W-1:0]  wd_cnt;

    logic             at_hi;
    logic             at_lo;
    logic             cfg_bad;
    logic             dwell_last;
    logic             wd_last;
    logic [REP_W-1:0] rp_eff;
    logic [REP_W-1:0] cycle_inc;
    logic             set_err;
    logic             in_ramp;
    logic             in_dwell;

    assign at_hi     = (cuenta == hi_q);
    assign at_lo     = (cuenta == lo_q);
    assign cfg_bad   = (lim_lo >= lim_hi);
    assign wd_last   = (wd_cnt == WD_LAST);
    assign rp_eff    = (rp_q == '0) ? REP_W'(1) : rp_q;
    assign cycle_inc = cycle_cnt + REP_W'(1);
    assign in_ramp   = (state == S_RAMP_UP) || (state == S_RAMP_DN);
    assign in_dwell  = (state == S_DWELL_HI) || (state == S_DWELL_LO);

    // A zero dwell still spends one cycle in the dwell state.
    assign dwell_last = (dw_q == '0) || (dw_cnt == (dw_q - REP_W'(1)));

    // The step enable drops in the turn cycle itself, so the counter sits on
    // the limit for one cycle before the dwell begins.
    assign cnt_en = ((state == S_RAMP_UP) && !at_hi) ||
                    ((state == S_RAMP_DN) && !at_lo);

    always_comb begin
        state_nxt = state;
        set_err   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (cfg_bad) begin
                        set_err = 1'b1;
                    end else begin
                        state_nxt = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                state_nxt = S_RAMP_UP;
            end
            S_RAMP_UP: begin
                // A turn seen in the watchdog's last cycle still wins.
                if (at_hi) begin
                    state_nxt = S_DWELL_HI;
                end else if (wd_last) begin
                    state_nxt = S_IDLE;
                    set_err   = 1'b1;
                end
            end
            S_DWELL_HI: begin
                if (dwell_last) begin
                    state_nxt = S_RAMP_DN;
                end
            end
            S_RAMP_DN: begin
                if (at_lo) begin
                    state_nxt = S_DWELL_LO;
                end else if (wd_last) begin
                    state_nxt = S_IDLE;
                    set_err   = 1'b1;
                end
            end
            S_DWELL_LO: begin
                if (dwell_last) begin
                    if (cycle_inc == rp_eff) begin
                        state_nxt = S_FINISH;
                    end else begin
                        state_nxt = S_RAMP_UP;
                    end
                end
            end
            S_FINISH: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Abort silently returns to IDLE; in IDLE a coincident start wins.
        if (abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
            set_err   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            hi_q        <= '0;
            lo_q        <= '0;
            dw_q        <= '0;
            rp_q        <= '0;
            dw_cnt      <= '0;
            wd_cnt      <= '0;
            cycle_cnt   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            cnt_clr     <= 1'b0;
            cnt_up_down <= 1'b1;
        end else begin
            state <= state_nxt;

            // Registered outputs are decoded from the next state so they
            // line up exactly with the state they describe.
            busy        <= (state_nxt != S_IDLE);
            cnt_clr     <= (state_nxt == S_CLEAR);
            cnt_up_down <= (state_nxt != S_RAMP_DN);
            done        <= (state_nxt == S_FINISH);
            err         <= set_err;

            if ((state == S_IDLE) && start) begin
                hi_q <= lim_hi;
                lo_q <= lim_lo;
                dw_q <= dwell;
                rp_q <= reps;
            end

            if (state_nxt == S_CLEAR) begin
                cycle_cnt <= '0;
            end else if ((state == S_DWELL_LO) &&
                         ((state_nxt == S_RAMP_UP) || (state_nxt == S_FINISH))) begin
                cycle_cnt <= cycle_inc;
            end

            if (in_dwell && (state_nxt == state)) begin
                dw_cnt <= dw_cnt + REP_W'(1);
            end else begin
                dw_cnt <= '0;
            end

            // Every entry into a ramp arrives from a non-ramp state, so this
            // also clears the watchdog on entry.
            if (in_ramp && (state_nxt == state)) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end else begin
                wd_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/contador_sweep_ctrl.md
Name: contador_sweep_ctrl

Overview:
Sequencer for the 8-bit up/down counter (`contador`). It drives the counter through a programmed triangular sweep and watches the counter's `cuenta` value to decide each turn.
- Sweep: clear, ramp up to `lim_hi`, dwell, ramp down to `lim_lo`, dwell, repeated `reps` times.
- Upstream control uses a start/busy/done handshake.
- The block detects bad configuration and stalled counters.

Parameters:
- WIDTH, 8, counter width; matches `cuenta`.
- REP_W, 4, width of the repeat and dwell fields.
- WDOG, 256, maximum cycles allowed in one ramp state before a stall error.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset; 0 forces the reset state immediately.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  return to IDLE from any state.
- lim_hi  in  WIDTH  upper turn value.
- lim_lo  in  WIDTH  lower turn value.
- dwell  in  REP_W  hold cycles at each turn.
- reps  in  REP_W  number of up/down periods; 0 is treated as 1.
- cuenta  in  WIDTH  current counter value.
- cnt_en  out  1  counter step enable.
- cnt_up_down  out  1  1 = count up, 0 = count down.
- cnt_clr  out  1  counter clear request.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  one-cycle pulse on config error or watchdog stall.
- cycle_cnt  out  REP_W  completed periods.

Behaviour:
- **Reset (rst=0):**
  - state=IDLE; `cnt_en`=0, `cnt_clr`=0, `cnt_up_down`=1, `busy`=0, `done`=0, `err`=0, `cycle_cnt`=0.
  - Internal dwell and watchdog counters = 0.
  - Reset mid-sweep aborts immediately; there is no done/err pulse.
- **Output timing:** all outputs are registered except `cnt_en`, which is combinational:
  - `cnt_en` = (state==RAMP_UP and cuenta!=hi_q) or (state==RAMP_DN and cuenta!=lo_q).
- **States:** IDLE, CLEAR, RAMP_UP, DWELL_HI, RAMP_DN, DWELL_LO, FINISH.
- **IDLE:**
  - On `start`, latch `lim_hi`, `lim_lo`, `dwell`, `reps` into hi_q, lo_q, dw_q, rp_q.
  - If lim_lo >= lim_hi: pulse `err` next cycle and stay in IDLE.
  - Otherwise go to CLEAR.
  - Input changes while busy have no effect.
- **CLEAR:** `cnt_clr`=1 for exactly one cycle, `cycle_cnt`←0, then go to RAMP_UP.
- **RAMP_UP:** `cnt_up_down`=1. When the sampled `cuenta`==hi_q, go to DWELL_HI (one cycle with `cnt_en`=0 at the turn point).
- **DWELL_HI / DWELL_LO:**
  - Hold with `cnt_en`=0 for dw_q cycles.
  - dw_q=0 leaves after exactly one cycle.
- **DWELL_HI exit:** go to RAMP_DN.
- **RAMP_DN:** `cnt_up_down`=0. When `cuenta`==lo_q, go to DWELL_LO.
- **DWELL_LO exit:**
  - `cycle_cnt`+1.
  - If the new value equals max(rp_q,1): go to FINISH.
  - Otherwise go to RAMP_UP; later up-ramps start from lo_q.
- **FINISH:** `done`=1 for one cycle, then IDLE. `cycle_cnt` holds its value until the next CLEAR.
- **Watchdog:**
  - Counts cycles spent in RAMP_UP or RAMP_DN; cleared on entering either state.
  - Reaching WDOG: pulse `err`, go to IDLE, `cnt_en`=0.
- **abort:**
  - In any non-IDLE state, next state is IDLE.
  - `cnt_en` drops in the same cycle (combinational on state only after the edge); no `done`.
  - If `abort` and `start` are both high in IDLE, `start` wins.
  - If `abort` coincides with the FINISH cycle, `done` still pulses.
- **Value ranges:** the sweep never wraps the counter because 0 <= lo_q < hi_q <= 2^WIDTH-1. lim_hi=255 is legal.

Test Plan:
- Reset during RAMP_UP at cuenta=3, rst=0 -> all outputs go to their reset values asynchronously; `busy`=0 before the next clk edge; no `done`/`err`.
- lim_hi=5, lim_lo=2, dwell=3, reps=2, start -> `cnt_clr` high 1 cycle; `cnt_en` high for 5+3+3+3=14 cycles total; `cuenta` sequence 0..5,4..2,3..5,4..2; `done` pulses once; `cycle_cnt`=2; `busy` low afterwards.
- lim_lo=7, lim_hi=7, start -> `err` pulses 1 cycle; `busy` never rises; `cnt_clr` never asserted.
- lim_hi=255, lim_lo=0, dwell=0, reps=0, start -> a single period runs; `cnt_en` high 255 cycles up and 255 down; DWELL states last 1 cycle each; `done` once; `cycle_cnt`=1.
- Counter model frozen (`cuenta` stuck at 4), lim_hi=10 -> `err` pulses after 256 RAMP_UP cycles; state returns to IDLE; `cnt_en`=0.
- `abort` asserted while cuenta=6 in RAMP_DN -> next cycle: IDLE, `busy`=0, `cnt_en`=0, no `done`; a new start afterwards runs normally from CLEAR.
